// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Round-robin shares the port between the ALU and load paths, registers the
// write toward register_file, and tracks outstanding loads per register so
// decode can stall on RAW hazards and the ALU path waits out WAW hazards.
module regfile_wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            nRST,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_index,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_index,
   input  logic [XLEN-1:0] mem_data,
   input  logic            ld_issue,
   input  logic [4:0]      ld_index,
   input  logic [4:0]      rs1_index,
   input  logic [4:0]      rs2_index,
   output logic            stall,
   output logic            reg_write,
   output logic [4:0]      write_index,
   output logic [XLEN-1:0] write_data,
   output logic [31:0]     pending,
   output logic            last_grant,
   output logic            mem_unexpected
);

   logic            reg_write_q, reg_write_d;
   logic [4:0]      write_index_q, write_index_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [31:0]     pending_q, pending_d;
   logic            last_grant_q, last_grant_d;
   logic            mem_unexpected_q, mem_unexpected_d;

   logic            alu_eligible, mem_eligible;
   logic            alu_hs, mem_hs;
   logic [4:0]      hs_index;
   logic [XLEN-1:0] hs_data;

   // A source register is hazardous while a load is outstanding to it or while
   // its value is still sitting in the write register, not yet committed.
   function automatic logic hz(input logic [4:0] r, input logic [31:0] pend,
                               input logic wr, input logic [4:0] widx);
      hz = (r != 5'd0) && (pend[r] || (wr && (widx == r)));
   endfunction

   // Eligibility, round-robin grant, and RAW stall (combinational from state)
   always_comb begin
      alu_eligible = alu_valid && !(pending_q[alu_index] && (alu_index != 5'd0));
      mem_eligible = mem_valid;
      // last_grant = 0 means the ALU won last, so MEM takes a tie
      alu_ready    = alu_eligible && (!mem_eligible || last_grant_q);
      mem_ready    = mem_eligible && (!alu_eligible || !last_grant_q);
      alu_hs       = alu_valid && alu_ready;
      mem_hs       = mem_valid && mem_ready;
      stall        = hz(rs1_index, pending_q, reg_write_q, write_index_q) ||
                     hz(rs2_index, pending_q, reg_write_q, write_index_q);
   end

   // Next-state for the write register, scoreboard and grant history
   always_comb begin
      hs_index         = mem_hs ? mem_index : alu_index;
      hs_data          = mem_hs ? mem_data  : alu_data;
      reg_write_d      = 1'b0;
      write_index_d    = write_index_q;
      write_data_d     = write_data_q;
      // index-0 handshakes complete but never disturb the write register
      if ((alu_hs || mem_hs) && (hs_index != 5'd0)) begin
         reg_write_d   = 1'b1;
         write_index_d = hs_index;
         write_data_d  = hs_data;
      end

      last_grant_d = last_grant_q;
      if (mem_hs)      last_grant_d = 1'b1;
      else if (alu_hs) last_grant_d = 1'b0;

      mem_unexpected_d = mem_hs && (mem_index != 5'd0) && !pending_q[mem_index];

      // clear first so a same-cycle issue to the same register wins
      pending_d = pending_q;
      if (mem_hs)   pending_d[mem_index] = 1'b0;
      if (ld_issue) pending_d[ld_index]  = 1'b1;
      pending_d[0] = 1'b0;
   end

   // State registers; reset drops any in-flight write immediately
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         reg_write_q      <= 1'b0;
         write_index_q    <= 5'd0;
         write_data_q     <= '0;
         pending_q        <= 32'd0;
         last_grant_q     <= 1'b0;
         mem_unexpected_q <= 1'b0;
      end else begin
         reg_write_q      <= reg_write_d;
         write_index_q    <= write_index_d;
         write_data_q     <= write_data_d;
         pending_q        <= pending_d;
         last_grant_q     <= last_grant_d;
         mem_unexpected_q <= mem_unexpected_d;
      end
   end

   assign reg_write      = reg_write_q;
   assign write_index    = write_index_q;
   assign write_data     = write_data_q;
   assign pending        = pending_q;
   assign last_grant     = last_grant_q;
   assign mem_unexpected = mem_unexpected_q;

endmodule
